// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one framebuffer RAM port between display prefetch FIFO and a graphics writer
module fb_scan_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int FRAME_WORDS = 153600,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WATER   = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              frame_start_i,
  input  logic              dvi_request_i,
  output logic [63:0]       dvi_data_o,
  output logic              underflow_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [63:0]       wr_data_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PW:0]       level_q, level_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d, underflow_q, underflow_d;
  logic [63:0]       dvi_data_q, dvi_data_d;
  logic [63:0]       fifo_q [FIFO_DEPTH];
  logic [PW+1:0]     occ;
  logic              live, disp_ok, urgent, wr_gnt, rd_gnt, push, pop;
  // Grant arbitration, FIFO bookkeeping and FSM next state; a frame_start cycle issues no display read so nothing is in flight during FLUSH
  always_comb begin
    occ          = {1'b0, level_q} + (PW+2)'(inflight_q);
    live         = state_q == RUN && enable_i && !frame_start_i;
    disp_ok      = live && !reset_i;
    urgent       = disp_ok && occ < (PW+2)'(LOW_WATER);
    wr_gnt       = !reset_i && !urgent && wr_valid_i;
    rd_gnt       = urgent || (disp_ok && !wr_valid_i && occ < (PW+2)'(FIFO_DEPTH));
    push         = live && inflight_q;
    pop          = live && dvi_request_i && level_q != '0;
    level_d      = live ? level_q + (PW+1)'(push) - (PW+1)'(pop) : '0;
    rd_ptr_d     = live ? rd_ptr_q + PW'(pop) : '0;
    wr_ptr_d     = live ? wr_ptr_q + PW'(push) : '0;
    inflight_d   = rd_gnt;
    fetch_addr_d = frame_start_i ? '0 :
                   !rd_gnt ? fetch_addr_q :
                   fetch_addr_q == ADDR_W'(FRAME_WORDS - 1) ? '0 : fetch_addr_q + ADDR_W'(1);
    underflow_d  = (state_q == RUN && frame_start_i) ? 1'b0 :
                   (dvi_request_i && level_q == '0) ? 1'b1 : underflow_q;
    dvi_data_d   = level_d == '0 ? dvi_data_q :
                   (push && wr_ptr_q == rd_ptr_d) ? mem_rdata_i : fifo_q[rd_ptr_d];
    state_d      = !enable_i ? IDLE :
                   state_q != RUN ? RUN :
                   frame_start_i ? FLUSH : RUN;
    mem_en_o     = wr_gnt || rd_gnt;
    mem_we_o     = wr_gnt;
    wr_ready_o   = wr_gnt;
    mem_addr_o   = wr_gnt ? wr_addr_i : fetch_addr_q;
    mem_wdata_o  = wr_data_i;
    dvi_data_o   = dvi_data_q;
    underflow_o  = underflow_q;
  end
  // Control and status registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      level_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
      dvi_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      level_q      <= level_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
      dvi_data_q   <= dvi_data_d;
    end
  end
  // FIFO storage captures the returning read word
  always_ff @(posedge clock_i) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata_i;
  end
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb_fb_scan_arbiter: directed checks of fb_scan_arbiter with a one-cycle-latency RAM model
module tb_fb_scan_arbiter;
  localparam int FW = 20;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, frame_start = 1'b0, dvi_request = 1'b0;
  logic        wr_valid = 1'b0;
  logic [17:0] wr_addr = '0;
  logic [63:0] wr_data = 64'h1234_5678_9ABC_DEF0;
  logic [63:0] dvi_data, mem_wdata, mem_rdata = '0;
  logic        underflow, wr_ready, mem_en, mem_we;
  logic [17:0] mem_addr;
  int          errors = 0, checks = 0;

  fb_scan_arbiter #(.FRAME_WORDS(FW)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .frame_start_i(frame_start),
    .dvi_request_i(dvi_request), .dvi_data_o(dvi_data), .underflow_o(underflow),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int a);
    return {32'hF00D_BEEF, 14'h0, 18'(a)};
  endfunction

  // RAM model: read data valid the cycle after the read is issued
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= word(int'(mem_addr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    wr_valid = 1'b1;
    @(negedge clk); #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_dvi_data", dvi_data, 0);
    check("rst_underflow", underflow, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    #1 check("idle_no_access", mem_en, 0);
    @(negedge clk);
    // T1: eight back-to-back prefetch reads from address 0
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t1_en", mem_en, 1);
      check("t1_we", mem_we, 0);
      check("t1_addr", mem_addr, i);
      @(negedge clk);
    end
    #1;
    check("t1_full_no_read", mem_en, 0);
    check("t1_head", dvi_data, word(0));
    @(negedge clk);
    // T2: writer beats non-urgent display, urgent display beats writer
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1; wr_addr = 18'(100 + k); dvi_request = 1'b1;
      #1;
      check("t2_head", dvi_data, word(k));
      if (k < 7) begin
        check("t2_wr_ready", wr_ready, 1);
        check("t2_wr_we", mem_we, 1);
        check("t2_wr_addr", mem_addr, 100 + k);
      end else begin
        check("t2_urgent_wr_ready", wr_ready, 0);
        check("t2_urgent_we", mem_we, 0);
        check("t2_urgent_en", mem_en, 1);
        check("t2_urgent_addr", mem_addr, 8);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0; dvi_request = 1'b0;
    #1 check("t2_next_addr", mem_addr, 9);
    @(negedge clk);
    #1 check("t2_refill_head", dvi_data, word(8));
    repeat (12) @(negedge clk);
    // T3: fetch address wraps FRAME_WORDS-1 -> 0 with data order kept
    for (int j = 0; j < 14; j++) begin
      dvi_request = 1'b1;
      #1;
      check("t3_head", dvi_data, word((8 + j) % FW));
      if (j == 0) check("t3_full_no_read", mem_en, 0);
      else check("t3_addr", mem_addr, (15 + j) % FW);
      @(negedge clk);
    end
    dvi_request = 1'b0;
    repeat (12) @(negedge clk);
    // T4: underflow on empty FIFO right after enable
    enable = 1'b0;
    #1 check("t4_disable_no_read", mem_en, 0);
    @(negedge clk);
    enable = 1'b1; dvi_request = 1'b1;
    #1 check("t4_idle_no_read", mem_en, 0);
    @(negedge clk);
    dvi_request = 1'b0;
    #1;
    check("t4_underflow", underflow, 1);
    check("t4_dvi_hold", dvi_data, word(2));
    check("t4_read_en", mem_en, 1);
    check("t4_read_addr", mem_addr, 10);
    @(negedge clk);
    // T5: frame_start with a read returning and a request in the same cycle
    frame_start = 1'b1; dvi_request = 1'b1;
    #1 check("t5_underflow_sticky", underflow, 1);
    @(negedge clk);
    frame_start = 1'b0; dvi_request = 1'b0;
    #1;
    check("t5_underflow_clr", underflow, 0);
    check("t5_flush_no_read", mem_en, 0);
    check("t5_dropped", dvi_data, word(2));
    @(negedge clk);
    #1;
    check("t5_restart_en", mem_en, 1);
    check("t5_restart_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    // T6: reset mid-write, then mid-read
    wr_valid = 1'b1; wr_addr = 18'h3_0000;
    #1;
    check("t5_first_word", dvi_data, word(0));
    check("t6_wr_ready", wr_ready, 1);
    check("t6_wr_addr", mem_addr, 18'h3_0000);
    check("t6_wdata", mem_wdata, wr_data);
    rst = 1'b1;
    #1;
    check("t6_rst_wr_ready", wr_ready, 0);
    check("t6_rst_en", mem_en, 0);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_dvi", dvi_data, 0);
    check("t6_rst_underflow", underflow, 0);
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t6_read_en", mem_en, 1);
    check("t6_read_addr", mem_addr, 0);
    rst = 1'b1;
    #1 check("t6_rst_read_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t6_reread_en", mem_en, 1);
    check("t6_reread_addr", mem_addr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
